// File: rtl/modulo_varredura_matriz.sv
// rtl/modulo_varredura_matriz.sv - row-scan controller for the 5x7 LED hour-tens display
module modulo_varredura_matriz #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [1:0]  HH_in,
  input  logic [34:0] cl_in,
  output logic [1:0]  HH,
  output logic [6:0]  linha,
  output logic [4:0]  coluna,
  output logic        frame_done
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SYNC, DRIVE, BLANK} state_t;

  state_t        state, state_nx;
  logic [2:0]    r, r_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    pend;
  logic          pend_valid;
  logic          row_start;

  always_comb begin
    state_nx = state;
    r_nx     = r;
    cnt_nx   = cnt;
    if (!enable) begin
      state_nx = IDLE;
      r_nx     = 3'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SYNC;
          r_nx     = 3'd0;
          cnt_nx   = '0;
        end
        SYNC: begin
          state_nx = DRIVE;
          r_nx     = 3'd0;
          cnt_nx   = '0;
        end
        DRIVE: begin
          if (cnt == DIV_LAST) begin
            cnt_nx = '0;
            if (BLANK_CYC > 0) begin
              state_nx = BLANK;
            end else if (r == 3'd6) begin
              state_nx = SYNC;
              r_nx     = 3'd0;
            end else begin
              state_nx = DRIVE;
              r_nx     = r + 3'd1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_nx = '0;
            if (r == 3'd6) begin
              state_nx = SYNC;
              r_nx     = 3'd0;
            end else begin
              state_nx = DRIVE;
              r_nx     = r + 3'd1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          r_nx     = 3'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // A new row begins on any DRIVE entry, including DRIVE->DRIVE when BLANK_CYC=0
  assign row_start = (state_nx == DRIVE) && ((state != DRIVE) || (cnt == DIV_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      r          <= 3'd0;
      cnt        <= '0;
      HH         <= 2'b00;
      pend       <= 2'b00;
      pend_valid <= 1'b0;
      linha      <= 7'b1111111;
      coluna     <= 5'b00000;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      r          <= r_nx;
      cnt        <= cnt_nx;
      frame_done <= (state_nx == SYNC) && (state != IDLE);

      // The digit only moves on SYNC entry so a frame never mixes two digits
      if (state_nx == SYNC) begin
        pend_valid <= 1'b0;
        if (load) begin
          HH <= HH_in;
        end else if (pend_valid) begin
          HH <= pend;
        end
      end else if (load) begin
        pend       <= HH_in;
        pend_valid <= 1'b1;
      end

      if (row_start) begin
        linha  <= ~(7'b0000001 << r_nx);
        coluna <= cl_in[5*r_nx +: 5];
      end else if (state_nx != DRIVE) begin
        linha  <= 7'b1111111;
        coluna <= 5'b00000;
      end
    end
  end

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// tb/tb_modulo_varredura_matriz.sv - bench for modulo_varredura_matriz against a frame-phase model
module tb_modulo_varredura_matriz;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [1:0]  HH_in;
  logic [34:0] cl0, cl1;
  logic [1:0]  hh0, hh1;
  logic [6:0]  ln0, ln1;
  logic [4:0]  co0, co1;
  logic        fd0, fd1;
  int          errors = 0;
  int          checks = 0;
  int          cnow;

  always #5 clk = ~clk;

  // Preset modules: digit in bits 4:3, row number + 1 in bits 2:0
  function automatic logic [4:0] pat(input logic [1:0] h, input int r);
    logic [4:0] v;
    v = {h, 3'b000} ^ 5'(r + 1);
    return v;
  endfunction

  function automatic logic [34:0] panel(input logic [1:0] h);
    logic [34:0] c;
    c = '0;
    for (int r = 0; r < 7; r++) c[5*r +: 5] = pat(h, r);
    return c;
  endfunction

  assign cl0 = panel(hh0);
  assign cl1 = panel(hh1);

  modulo_varredura_matriz #(.DIV(4), .BLANK_CYC(1)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .HH_in(HH_in),
    .cl_in(cl0), .HH(hh0), .linha(ln0), .coluna(co0), .frame_done(fd0)
  );

  modulo_varredura_matriz #(.DIV(1), .BLANK_CYC(0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .HH_in(HH_in),
    .cl_in(cl1), .HH(hh1), .linha(ln1), .coluna(co1), .frame_done(fd1)
  );

  // Model: position within the frame, phase 0 = SYNC cycle
  int         mdiv [2] = '{4, 1};
  int         mblk [2] = '{1, 0};
  bit         run  [2];
  int         ph   [2];
  logic [1:0] mhh  [2];
  logic [1:0] mpd  [2];
  bit         mpv  [2];
  bit         mfd  [2];

  always @(posedge clk) begin
    int per;
    bit enter;
    for (int i = 0; i < 2; i++) begin
      per    = 1 + 7 * (mdiv[i] + mblk[i]);
      enter  = 1'b0;
      mfd[i] = 1'b0;
      if (reset) begin
        run[i] = 1'b0; ph[i] = 0; mhh[i] = 2'b00; mpd[i] = 2'b00; mpv[i] = 1'b0;
      end else begin
        if (!enable) begin
          run[i] = 1'b0; ph[i] = 0;
        end else if (!run[i]) begin
          run[i] = 1'b1; ph[i] = 0; enter = 1'b1;
        end else begin
          ph[i]  = (ph[i] + 1) % per;
          enter  = (ph[i] == 0);
          mfd[i] = enter;
        end
        if (enter) begin
          if (load) mhh[i] = HH_in;
          else if (mpv[i]) mhh[i] = mpd[i];
          mpv[i] = 1'b0;
        end else if (load) begin
          mpd[i] = HH_in;
          mpv[i] = 1'b1;
        end
      end
    end
  end

  task automatic expect_out(input int i, output logic [6:0] el, output logic [4:0] ec);
    int k, row, w, per_row;
    el = 7'h7f;
    ec = 5'h00;
    if (run[i] && ph[i] != 0) begin
      per_row = mdiv[i] + mblk[i];
      k   = ph[i] - 1;
      row = k / per_row;
      w   = k % per_row;
      if (w < mdiv[i]) begin
        el = 7'h7f & ~(7'd1 << row);
        ec = pat(mhh[i], row);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] el;
    logic [4:0] ec;
    expect_out(0, el, ec);
    chk("hh0", 32'(hh0), 32'(mhh[0]));
    chk("linha0", 32'(ln0), 32'(el));
    chk("coluna0", 32'(co0), 32'(ec));
    chk("frame_done0", 32'(fd0), 32'(mfd[0]));
    expect_out(1, el, ec);
    chk("hh1", 32'(hh1), 32'(mhh[1]));
    chk("linha1", 32'(ln1), 32'(el));
    chk("coluna1", 32'(co1), 32'(ec));
    chk("frame_done1", 32'(fd1), 32'(mfd[1]));
  end

  task automatic goto(input int n);
    while (cnow < n) begin
      @(posedge clk);
      #1;
      cnow++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; HH_in = 2'b00; cnow = 0;
    goto(3);  reset = 1'b0;
    goto(15);
    chk("lit_idle_linha", 32'(ln0), 32'h7f);
    chk("lit_idle_coluna", 32'(co0), 32'h0);
    chk("lit_idle_hh", 32'(hh0), 32'h0);
    chk("lit_idle_fd", 32'(fd0), 32'h0);

    cnow = 0; enable = 1'b1;
    goto(1);   chk("lit_sync_fd", 32'(fd0), 32'h0);  chk("lit_sync_linha", 32'(ln0), 32'h7f);
    goto(2);   chk("lit_row0_linha", 32'(ln0), 32'b1111110); chk("lit_row0_coluna", 32'(co0), 32'b00001);
               chk("lit_fast_row0_coluna", 32'(co1), 32'b00001);
    goto(6);   chk("lit_blank_linha", 32'(ln0), 32'h7f);
    goto(7);   chk("lit_row1_linha", 32'(ln0), 32'b1111101); chk("lit_row1_coluna", 32'(co0), 32'b00010);
    goto(9);   chk("lit_fast_fd", 32'(fd1), 32'h1);
    goto(32);  chk("lit_row6_linha", 32'(ln0), 32'b0111111); chk("lit_row6_coluna", 32'(co0), 32'b00111);
    goto(37);  chk("lit_frame_fd", 32'(fd0), 32'h1);

    goto(54);  load = 1'b1; HH_in = 2'b10;
    goto(55);  load = 1'b0;
    goto(60);  chk("lit_hh_held", 32'(hh0), 32'h0);
    goto(73);  chk("lit_hh_applied", 32'(hh0), 32'h2);
    goto(74);  chk("lit_row0_hh2", 32'(co0), 32'b10001);

    goto(80);  load = 1'b1; HH_in = 2'b11;
    goto(81);  load = 1'b0;
    goto(90);  load = 1'b1; HH_in = 2'b01;
    goto(91);  load = 1'b0;
    goto(109); chk("lit_last_load_wins", 32'(hh0), 32'h1);
    goto(144); chk("lit_pre_coincident", 32'(hh0), 32'h1);
               load = 1'b1; HH_in = 2'b11;
    goto(145); load = 1'b0; chk("lit_coincident_load", 32'(hh0), 32'h3);

    goto(157); enable = 1'b0;
    goto(158); chk("lit_dis_linha", 32'(ln0), 32'h7f); chk("lit_dis_coluna", 32'(co0), 32'h0);
               chk("lit_dis_hh", 32'(hh0), 32'h3);
    goto(160); enable = 1'b1;
    goto(161); chk("lit_reen_fd", 32'(fd0), 32'h0);
    goto(162); chk("lit_reen_row0", 32'(ln0), 32'b1111110); chk("lit_reen_coluna", 32'(co0), 32'b11001);

    goto(180); load = 1'b1; HH_in = 2'b10;
    goto(181); load = 1'b0;
    goto(188); reset = 1'b1;
    goto(189); reset = 1'b0; chk("lit_rst_hh", 32'(hh0), 32'h0); chk("lit_rst_linha", 32'(ln0), 32'h7f);
    goto(190); chk("lit_rst_sync_fd", 32'(fd0), 32'h0);
    goto(191); chk("lit_rst_row0", 32'(ln0), 32'b1111110); chk("lit_rst_pend_dropped", 32'(hh0), 32'h0);

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) != 0);
      load   = ($urandom_range(0, 19) == 0);
      HH_in  = 2'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
